cmd_phy_controller: RTL and testbench

Parametrised command-line physical-layer controller for the SD host CMD path. It sits between the CMD engine (strobe/ack handshake) and the parallel-to-serial / serial-to-parallel wrappers plus the bidirectional CMD pad. It sequences command transmission, pad turnaround, response reception with timeout, and handshaken delivery. Beyond the previous generation it adds selectable short/long responses, a configurable turnaround gap, bounded automatic retry on timeout, and deterministic abort.

---
 rtl/cmd_phy_pkg.sv | 35 +++
 rtl/cmd_phy_if.sv | 32 +++
 rtl/cmd_phy_timer.sv | 21 ++
 rtl/cmd_phy_controller.sv | 157 +++++++++++++++
 tb/tb_cmd_phy_controller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_phy_pkg.sv
// cmd_phy_pkg: shared state encoding and defaults
// for the SD host CMD physical-layer controller.
package cmd_phy_pkg;

  localparam int RESP_LONG_W_D  = 136;
  localparam int RESP_SHORT_W_D = 48;
  localparam int TIMEOUT_D      = 64;
  localparam int NCC_D          = 2;
  localparam int MAX_RETRIES_D  = 1;

  localparam int I_IDLE    = 0;
  localparam int I_LOAD    = 1;
  localparam int I_SEND    = 2;
  localparam int I_TURN    = 3;
  localparam int I_WAIT    = 4;
  localparam int I_DELIVER = 5;
  localparam int I_ACK     = 6;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_LOAD    = 7'b0000010,
    S_SEND    = 7'b0000100,
    S_TURN    = 7'b0001000,
    S_WAIT    = 7'b0010000,
    S_DELIVER = 7'b0100000,
    S_ACK     = 7'b1000000
  } state_e;

  function automatic int timer_w(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cmd_phy_if.sv
// cmd_phy_if: CMD engine <-> PHY controller
// strobe/ack handshake bundle.
interface cmd_phy_if #(
  parameter int RESP_LONG_W = 136
);
  logic                   strobe_in;
  logic                   ack_in;
  logic                   idle_in;
  logic                   no_response;
  logic                   long_response;
  logic                   ack_out;
  logic                   strobe_out;
  logic                   command_timeout;
  logic [RESP_LONG_W-1:0] response;
  logic [2:0]             retries_used;

  modport master (
    output strobe_in, ack_in, idle_in,
    output no_response, long_response,
    input  ack_out, strobe_out,
    input  command_timeout, response,
    input  retries_used
  );

  modport slave (
    input  strobe_in, ack_in, idle_in,
    input  no_response, long_response,
    output ack_out, strobe_out,
    output command_timeout, response,
    output retries_used
  );
endinterface

// File: rtl/cmd_phy_timer.sv
// cmd_phy_timer: up-counter with clear and
// terminal-count compare for TURN / WAIT_RESP.
module cmd_phy_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (en)        cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == term);
endmodule

// File: rtl/cmd_phy_controller.sv
// cmd_phy_controller: sequences CMD transmit,
// pad turnaround, response receive/retry, delivery.
module cmd_phy_controller
  import cmd_phy_pkg::*;
#(
  parameter int RESP_LONG_W    = RESP_LONG_W_D,
  parameter int RESP_SHORT_W   = RESP_SHORT_W_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_D,
  parameter int NCC_CYCLES     = NCC_D,
  parameter int MAX_RETRIES    = MAX_RETRIES_D
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  cmd_phy_if.slave               eng,
  input  logic [RESP_LONG_W-1:0] pad_response,
  input  logic                   reception_complete,
  input  logic                   transmission_complete,
  output logic                   load_send,
  output logic                   enable_pts_wrapper,
  output logic                   enable_stp_wrapper,
  output logic                   stp_long,
  output logic                   reset_wrapper,
  output logic                   pad_state,
  output logic                   pad_enable
);
  localparam int TW = timer_w(TIMEOUT_CYCLES, NCC_CYCLES);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);
  localparam logic [RESP_LONG_W-1:0] SHORT_MASK =
    {RESP_LONG_W{1'b1}} >> (RESP_LONG_W - RESP_SHORT_W);

  state_e                 state, state_n;
  logic [RESP_LONG_W-1:0] resp_r;
  logic                   tmo_r, no_resp_r, long_r;
  logic [2:0]             retries_r;
  logic                   accept, cap, retry, tmo;
  logic                   tc;
  logic [TW-1:0]          term;

  assign term = state[I_TURN] ? TW'(NCC_CYCLES - 1)
                              : TW'(TIMEOUT_CYCLES - 1);

  cmd_phy_timer #(.W(TW)) u_timer (
    .clk   (sd_clock),
    .reset (reset),
    .clear (state_n != state),
    .en    (state[I_TURN] | state[I_WAIT]),
    .term  (term),
    .tc    (tc)
  );

  always_comb begin
    state_n            = state;
    accept             = 1'b0;
    cap                = 1'b0;
    retry              = 1'b0;
    tmo                = 1'b0;
    load_send          = 1'b0;
    enable_pts_wrapper = 1'b0;
    enable_stp_wrapper = 1'b0;
    stp_long           = 1'b0;
    reset_wrapper      = 1'b0;
    pad_state          = 1'b0;
    pad_enable         = 1'b0;
    eng.strobe_out     = 1'b0;
    eng.ack_out        = 1'b0;
    unique case (1'b1)
      state[I_IDLE]: begin
        reset_wrapper = 1'b1;
        if (eng.strobe_in && !eng.idle_in) begin
          accept  = 1'b1;
          state_n = S_LOAD;
        end
      end
      state[I_LOAD]: begin
        enable_pts_wrapper = 1'b1;
        pad_state          = 1'b1;
        pad_enable         = 1'b1;
        state_n            = S_SEND;
      end
      state[I_SEND]: begin
        enable_pts_wrapper = 1'b1;
        pad_state          = 1'b1;
        pad_enable         = 1'b1;
        load_send          = 1'b1;
        if (transmission_complete)
          state_n = no_resp_r ? S_DELIVER : S_TURN;
      end
      state[I_TURN]: begin
        if (tc) state_n = S_WAIT;
      end
      state[I_WAIT]: begin
        enable_stp_wrapper = 1'b1;
        stp_long           = long_r;
        // reception wins over a coincident timeout
        if (reception_complete) begin
          cap     = 1'b1;
          state_n = S_DELIVER;
        end else if (tc) begin
          if (retries_r < MAX_R) begin
            retry   = 1'b1;
            state_n = S_LOAD;
          end else begin
            tmo     = 1'b1;
            state_n = S_DELIVER;
          end
        end
      end
      state[I_DELIVER]: begin
        eng.strobe_out = 1'b1;
        if (eng.ack_in) state_n = S_ACK;
      end
      state[I_ACK]: begin
        eng.ack_out = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (eng.idle_in && !state[I_IDLE] && !state[I_ACK]) begin
      state_n = S_IDLE;
      cap     = 1'b0;
      retry   = 1'b0;
      tmo     = 1'b0;
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      resp_r    <= '0;
      tmo_r     <= 1'b0;
      retries_r <= 3'd0;
      no_resp_r <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        no_resp_r <= eng.no_response;
        long_r    <= eng.long_response;
        resp_r    <= '0;
        tmo_r     <= 1'b0;
        retries_r <= 3'd0;
      end
      if (cap)
        resp_r <= long_r ? pad_response
                         : (pad_response & SHORT_MASK);
      if (retry) retries_r <= retries_r + 3'd1;
      if (tmo) begin
        tmo_r  <= 1'b1;
        resp_r <= '0;
      end
    end
  end

  assign eng.response        = resp_r;
  assign eng.command_timeout = tmo_r;
  assign eng.retries_used    = retries_r;
endmodule

// File: tb/tb_cmd_phy_controller.sv
// tb_cmd_phy_controller: directed checks of
// cmd_phy_controller with default parameters.
module tb_cmd_phy_controller;
  logic         sd_clock = 1'b0;
  logic         reset;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         transmission_complete;
  logic         load_send, enable_pts_wrapper;
  logic         enable_stp_wrapper, stp_long;
  logic         reset_wrapper, pad_state, pad_enable;
  int           checks = 0;
  int           errors = 0;

  localparam logic [135:0] PAD_S =
    {88'h1234_5678_9ABC_DEF0_1122_33, 48'hA5_0000_0901};
  localparam logic [135:0] EXP_S = 136'hA5_0000_0901;
  localparam logic [135:0] PAD_L =
    136'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F_AB;

  cmd_phy_if #(.RESP_LONG_W(136)) bus ();

  cmd_phy_controller dut (
    .sd_clock              (sd_clock),
    .reset                 (reset),
    .eng                   (bus.slave),
    .pad_response          (pad_response),
    .reception_complete    (reception_complete),
    .transmission_complete (transmission_complete),
    .load_send             (load_send),
    .enable_pts_wrapper    (enable_pts_wrapper),
    .enable_stp_wrapper    (enable_stp_wrapper),
    .stp_long              (stp_long),
    .reset_wrapper         (reset_wrapper),
    .pad_state             (pad_state),
    .pad_enable            (pad_enable)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic step();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic check(string tag, logic [135:0] obs,
                       logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // {rst_wr, pts, stp, load_send, pad_state, pad_en}
  function automatic logic [5:0] ctl();
    return {reset_wrapper, enable_pts_wrapper,
            enable_stp_wrapper, load_send,
            pad_state, pad_enable};
  endfunction

  task automatic request(logic nr, logic lg);
    bus.no_response   = nr;
    bus.long_response = lg;
    bus.strobe_in     = 1'b1;
    step();
    bus.strobe_in     = 1'b0;
  endtask

  task automatic send_done();
    transmission_complete = 1'b1;
    step();
    transmission_complete = 1'b0;
  endtask

  initial begin
    reset                 = 1'b1;
    bus.strobe_in         = 1'b0;
    bus.ack_in            = 1'b0;
    bus.idle_in           = 1'b0;
    bus.no_response       = 1'b0;
    bus.long_response     = 1'b0;
    pad_response          = '0;
    reception_complete    = 1'b0;
    transmission_complete = 1'b0;
    step();
    step();
    check("rst_ctl", 136'(ctl()), 136'(6'b100000));
    check("rst_resp", bus.response, '0);
    check("rst_hs", 136'({bus.strobe_out, bus.ack_out,
          bus.command_timeout, bus.retries_used}), '0);
    reset = 1'b0;
    step();

    // short response
    request(1'b0, 1'b0);
    check("load_ctl", 136'(ctl()), 136'(6'b010011));
    step();
    check("send_ctl", 136'(ctl()), 136'(6'b010111));
    repeat (46) step();
    send_done();
    check("turn1", 136'(ctl()), 136'(6'b000000));
    step();
    check("turn2", 136'(ctl()), 136'(6'b000000));
    step();
    check("wait_ctl", 136'(ctl()), 136'(6'b001000));
    check("wait_short", 136'(stp_long), 136'(1'b0));
    pad_response       = PAD_S;
    reception_complete = 1'b1;
    step();
    reception_complete = 1'b0;
    pad_response       = '0;
    check("s_strobe", 136'(bus.strobe_out), 136'(1'b1));
    check("s_resp", bus.response, EXP_S);
    check("s_tmo", 136'(bus.command_timeout), 136'(1'b0));
    step();
    step();
    check("s_hold", 136'(bus.strobe_out), 136'(1'b1));
    check("s_noack", 136'(bus.ack_out), 136'(1'b0));
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    check("s_ack", 136'({bus.ack_out, bus.strobe_out}),
          136'(2'b10));
    step();
    check("s_idle", 136'({bus.ack_out, reset_wrapper}),
          136'(2'b01));

    // no-response command
    request(1'b1, 1'b0);
    step();
    send_done();
    check("nr_strobe", 136'(bus.strobe_out), 136'(1'b1));
    check("nr_ctl", 136'(ctl()), 136'(6'b000000));
    check("nr_resp", bus.response, '0);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    check("nr_ack", 136'(bus.ack_out), 136'(1'b1));
    step();

    // timeout with one retry
    request(1'b0, 1'b0);
    step();
    send_done();
    step();
    step();
    check("t_wait", 136'(enable_stp_wrapper), 136'(1'b1));
    repeat (63) step();
    check("t_wait63", 136'(enable_stp_wrapper), 136'(1'b1));
    step();
    check("t_reload", 136'(ctl()), 136'(6'b010011));
    check("t_retry", 136'(bus.retries_used), 136'(3'd1));
    step();
    send_done();
    step();
    step();
    repeat (63) step();
    check("t_wait2", 136'(bus.strobe_out), 136'(1'b0));
    step();
    check("t_strobe", 136'(bus.strobe_out), 136'(1'b1));
    check("t_tmo", 136'(bus.command_timeout), 136'(1'b1));
    check("t_resp", bus.response, '0);
    check("t_rused", 136'(bus.retries_used), 136'(3'd1));
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    step();

    // long response on the timeout cycle
    request(1'b0, 1'b1);
    check("l_clr", 136'({bus.command_timeout,
          bus.retries_used}), '0);
    step();
    send_done();
    step();
    step();
    check("l_stplong", 136'(stp_long), 136'(1'b1));
    repeat (63) step();
    pad_response       = PAD_L;
    reception_complete = 1'b1;
    step();
    reception_complete = 1'b0;
    pad_response       = '0;
    check("l_resp", bus.response, PAD_L);
    check("l_tmo", 136'({bus.command_timeout,
          bus.retries_used}), '0);
    check("l_strobe", 136'(bus.strobe_out), 136'(1'b1));
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    step();

    // abort during SEND
    request(1'b0, 1'b0);
    step();
    bus.idle_in = 1'b1;
    step();
    bus.idle_in = 1'b0;
    check("a_send", 136'({ctl(), bus.ack_out,
          bus.strobe_out}), 136'(8'b10000000));
    step();
    check("a_send2", 136'(bus.ack_out), 136'(1'b0));

    // abort during DELIVER keeps response
    request(1'b1, 1'b0);
    step();
    send_done();
    check("a_dlv", 136'(bus.strobe_out), 136'(1'b1));
    bus.idle_in = 1'b1;
    step();
    bus.idle_in = 1'b0;
    check("a_dlv_idle", 136'({ctl(), bus.ack_out,
          bus.strobe_out}), 136'(8'b10000000));
    step();
    check("a_dlv_noack", 136'(bus.ack_out), 136'(1'b0));

    // reset mid-WAIT_RESP after a retry
    request(1'b0, 1'b1);
    step();
    send_done();
    step();
    step();
    repeat (64) step();
    check("r_retry", 136'(bus.retries_used), 136'(3'd1));
    step();
    send_done();
    step();
    step();
    repeat (5) step();
    check("r_inwait", 136'(enable_stp_wrapper), 136'(1'b1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r_ctl", 136'(ctl()), 136'(6'b100000));
    check("r_flags", 136'({bus.strobe_out, bus.ack_out,
          bus.command_timeout, bus.retries_used,
          stp_long}), '0);
    request(1'b0, 1'b0);
    check("r_newload", 136'(ctl()), 136'(6'b010011));
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
